// File: rtl/imem_pkg.sv
`timescale 1ns/1ps
// Shared instruction-memory geometry and fetch-stage state encoding.
package imem_pkg;

    localparam int IMEM_AW = 6;
    localparam int IMEM_DW = 32;

    localparam logic [IMEM_DW-1:0] NOP = 32'h0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DEBUG = 2'd2,
        HALT  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_dbg_arb.sv
`timescale 1ns/1ps
// Debug read-port arbiter: grants when the memory port is free, otherwise counts
// denied request cycles and asks the fetch FSM for a DEBUG slot once starved.
module fetch_dbg_arb
    import imem_pkg::*;
#(
    parameter int DBG_STARVE = 4
) (
    input  logic               clk,
    input  logic               srst,
    input  logic               dbg_req,
    input  logic               mem_free,
    input  logic               in_debug,
    input  logic [IMEM_DW-1:0] rd_data,
    output logic               dbg_gnt,
    output logic               starve,
    output logic               dbg_valid,
    output logic [IMEM_DW-1:0] dbg_data
);

    localparam int CW = $clog2(DBG_STARVE + 1);

    logic [CW-1:0]      cnt_q, cnt_d;
    logic               dbg_valid_q, dbg_valid_d;
    logic [IMEM_DW-1:0] dbg_data_q, dbg_data_d;

    always_comb begin
        // Gating with srst keeps a read from starting in a reset cycle.
        dbg_gnt     = dbg_req && !srst && (mem_free || in_debug);
        starve      = 1'b0;
        cnt_d       = '0;
        if (dbg_req && !dbg_gnt) begin
            cnt_d  = (cnt_q < CW'(DBG_STARVE)) ? cnt_q + 1'b1 : cnt_q;
            starve = (cnt_d == CW'(DBG_STARVE));
        end
        dbg_valid_d = dbg_gnt;
        dbg_data_d  = dbg_gnt ? rd_data : dbg_data_q;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q       <= '0;
            dbg_valid_q <= 1'b0;
            dbg_data_q  <= NOP;
        end else begin
            cnt_q       <= cnt_d;
            dbg_valid_q <= dbg_valid_d;
            dbg_data_q  <= dbg_data_d;
        end
    end

    assign dbg_valid = dbg_valid_q;
    assign dbg_data  = dbg_data_q;

endmodule

// File: rtl/fetch_controller.sv
`timescale 1ns/1ps
// Instruction fetch stage: PC sequencing, IF/ID register, halt after END_ADDR.
// Macro FETCH_DEBUG_PORT_EN adds the debug read port and its starvation arbiter.
module fetch_controller
    import imem_pkg::*;
#(
    parameter logic [IMEM_AW-1:0] END_ADDR   = 6'd26,
    parameter int                 DBG_STARVE = 4
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Stall,
    input  logic               BranchTaken,
    input  logic [IMEM_AW-1:0] BranchTarget,
    output logic [IMEM_AW-1:0] ImemAddress,
    input  logic [IMEM_DW-1:0] ImemReadData,
    output logic [IMEM_DW-1:0] Instruction,
    output logic [IMEM_AW-1:0] InstrPC,
    output logic               InstrValid,
    output logic               Halted,
    input  logic               DbgReq,
    input  logic [IMEM_AW-1:0] DbgAddr,
    output logic               DbgGnt,
    output logic [IMEM_DW-1:0] DbgData,
    output logic               DbgValid
);

    fetch_state_e       state_q, state_d;
    logic [IMEM_AW-1:0] pc_q, pc_d;
    logic [IMEM_AW-1:0] instr_pc_q, instr_pc_d;
    logic [IMEM_DW-1:0] instr_q, instr_d;
    logic               instr_valid_q, instr_valid_d;
    logic               halted_q, halted_d;
    logic               dbg_gnt, starve, mem_free;

    // The address port is idle when no fetch is consuming it this cycle.
    assign mem_free = (state_q == IDLE) || (state_q == HALT) ||
                      ((state_q == FETCH) && (Stall || BranchTaken));

`ifdef FETCH_DEBUG_PORT_EN
    fetch_dbg_arb #(
        .DBG_STARVE (DBG_STARVE)
    ) u_dbg_arb (
        .clk       (Clk),
        .srst      (Reset),
        .dbg_req   (DbgReq),
        .mem_free  (mem_free),
        .in_debug  (state_q == DEBUG),
        .rd_data   (ImemReadData),
        .dbg_gnt   (dbg_gnt),
        .starve    (starve),
        .dbg_valid (DbgValid),
        .dbg_data  (DbgData)
    );

    assign ImemAddress = dbg_gnt ? DbgAddr : pc_q;
`else
    logic unused_dbg;

    assign dbg_gnt     = 1'b0;
    assign starve      = 1'b0;
    assign DbgValid    = 1'b0;
    assign DbgData     = NOP;
    assign ImemAddress = pc_q;
    assign unused_dbg  = ^{DbgReq, DbgAddr, mem_free, 32'(DBG_STARVE)};
`endif

    assign DbgGnt = dbg_gnt;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        if (BranchTaken) begin
            pc_d          = BranchTarget;
            instr_valid_d = 1'b0;
            state_d       = FETCH;
        end else begin
            case (state_q)
                IDLE: state_d = FETCH;
                FETCH: begin
                    if (!Stall) begin
                        instr_d       = ImemReadData;
                        instr_pc_d    = pc_q;
                        instr_valid_d = 1'b1;
                        pc_d          = pc_q + 1'b1;
                        if (pc_q == END_ADDR) begin
                            state_d = HALT;
                        end else if (starve) begin
                            state_d = DEBUG;
                        end
                    end
                end
                DEBUG: begin
                    // A stalled IF/ID word is still pending, so only drop it once consumed.
                    if (!Stall) begin
                        instr_valid_d = 1'b0;
                    end
                    state_d = FETCH;
                end
                HALT: begin
                    if (!Stall) begin
                        instr_valid_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        halted_d = (state_d == HALT);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            instr_q       <= NOP;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            halted_q      <= halted_d;
        end
    end

    assign Instruction = instr_q;
    assign InstrPC     = instr_pc_q;
    assign InstrValid  = instr_valid_q;
    assign Halted      = halted_q;

endmodule

// File: tb/tb_fetch_controller.sv
`timescale 1ns/1ps
// Directed bench for fetch_controller: IF/ID expectations go through a scoreboard queue,
// debug-port behaviour is checked per build (FETCH_DEBUG_PORT_EN defined or not).
module tb_fetch_controller;

    logic        Clk = 1'b0;
    logic        Reset, Stall, BranchTaken, DbgReq;
    logic [5:0]  BranchTarget, DbgAddr, ImemAddress, InstrPC;
    logic [31:0] ImemReadData, Instruction, DbgData;
    logic        InstrValid, Halted, DbgGnt, DbgValid;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       valid;
        logic [5:0] pc;
    } ifid_t;

    ifid_t sb_q[$];

    always #5 Clk = ~Clk;

    function automatic logic [31:0] imem_word(input logic [5:0] a);
        return 32'hA500_0000 + ({26'd0, a} * 32'h0001_0101);
    endfunction

    assign ImemReadData = imem_word(ImemAddress);

    fetch_controller #(
        .END_ADDR   (6'd26),
        .DBG_STARVE (4)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Stall        (Stall),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .ImemAddress  (ImemAddress),
        .ImemReadData (ImemReadData),
        .Instruction  (Instruction),
        .InstrPC      (InstrPC),
        .InstrValid   (InstrValid),
        .Halted       (Halted),
        .DbgReq       (DbgReq),
        .DbgAddr      (DbgAddr),
        .DbgGnt       (DbgGnt),
        .DbgData      (DbgData),
        .DbgValid     (DbgValid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic stall, input logic br, input logic [5:0] tgt,
                         input logic req, input logic [5:0] daddr);
        Stall        = stall;
        BranchTaken  = br;
        BranchTarget = tgt;
        DbgReq       = req;
        DbgAddr      = daddr;
        #2;
    endtask

    task automatic push_exp(input logic v, input logic [5:0] pc);
        ifid_t e;
        e.valid = v;
        e.pc    = pc;
        sb_q.push_back(e);
    endtask

    task automatic tick_check(input string tag);
        ifid_t e;
        @(posedge Clk);
        #1;
        chk({tag, "_sb_depth"}, sb_q.size(), 1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk({tag, "_valid"}, InstrValid, e.valid);
            if (e.valid) begin
                chk({tag, "_pc"}, InstrPC, e.pc);
                chk({tag, "_instr"}, Instruction, imem_word(e.pc));
            end
            $display("step %s: valid=%0b pc=%0d instr=%h addr=%0d halted=%0b",
                     tag, InstrValid, InstrPC, Instruction, ImemAddress, Halted);
        end
    endtask

    task automatic step(input string tag, input logic stall, input logic exp_v,
                        input logic [5:0] exp_pc);
        drive(stall, 1'b0, 6'd0, 1'b0, 6'd0);
        push_exp(exp_v, exp_pc);
        tick_check(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        Reset = 1'b1;
        drive(1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_instr", Instruction, 32'h0);
        chk("rst_pc", InstrPC, 6'd0);
        chk("rst_valid", InstrValid, 1'b0);
        chk("rst_halted", Halted, 1'b0);
        chk("rst_gnt", DbgGnt, 1'b0);
        chk("rst_dvalid", DbgValid, 1'b0);
        chk("rst_ddata", DbgData, 32'h0);
        chk("rst_addr", ImemAddress, 6'd0);

        // IDLE cycle, then sequential fetch of 0..4
        Reset = 1'b0;
        step("idle", 1'b0, 1'b0, 6'd0);
        for (int i = 0; i < 5; i++) begin
            step($sformatf("run%0d", i), 1'b0, 1'b1, 6'(i));
        end
        chk("pre_stall_addr", ImemAddress, 6'd5);

        // Stall at PC=5 holds IF/ID and PC
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 6'd0, 1'b0, 6'd0);
            chk("stall_addr", ImemAddress, 6'd5);
            push_exp(1'b1, 6'd4);
            tick_check($sformatf("stall%0d", i));
        end
        step("unstall", 1'b0, 1'b1, 6'd5);
        chk("unstall_addr", ImemAddress, 6'd6);

        // Branch wins over stall
        drive(1'b1, 1'b1, 6'd20, 1'b0, 6'd0);
        push_exp(1'b0, 6'd0);
        tick_check("br_stall");
        chk("br_addr", ImemAddress, 6'd20);

        for (int i = 20; i <= 26; i++) begin
            step($sformatf("run%0d", i), 1'b0, 1'b1, 6'(i));
        end
        chk("halt_entry", Halted, 1'b1);

        for (int i = 0; i < 2; i++) begin
            step($sformatf("halt%0d", i), 1'b0, 1'b0, 6'd0);
            chk("halt_flag", Halted, 1'b1);
            chk("halt_addr", ImemAddress, 6'd27);
        end

        // Debug request while halted
        drive(1'b0, 1'b0, 6'd0, 1'b1, 6'd9);
`ifdef FETCH_DEBUG_PORT_EN
        chk("halt_dbg_gnt", DbgGnt, 1'b1);
        chk("halt_dbg_addr", ImemAddress, 6'd9);
`else
        chk("halt_dbg_gnt", DbgGnt, 1'b0);
        chk("halt_dbg_addr", ImemAddress, 6'd27);
`endif
        push_exp(1'b0, 6'd0);
        tick_check("halt_dbg");
`ifdef FETCH_DEBUG_PORT_EN
        chk("halt_dbg_valid", DbgValid, 1'b1);
        chk("halt_dbg_data", DbgData, imem_word(6'd9));
`else
        chk("halt_dbg_valid", DbgValid, 1'b0);
        chk("halt_dbg_data", DbgData, 32'h0);
`endif

        // Branch out of HALT to 0
        drive(1'b0, 1'b1, 6'd0, 1'b0, 6'd0);
        push_exp(1'b0, 6'd0);
        tick_check("resume");
        chk("resume_halted", Halted, 1'b0);
        chk("resume_dvalid", DbgValid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step($sformatf("rerun%0d", i), 1'b0, 1'b1, 6'(i));
        end

        // Debug request during continuous fetch: four denied cycles
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 6'd0, 1'b1, 6'd7);
            chk("starve_gnt", DbgGnt, 1'b0);
            chk("starve_addr", ImemAddress, 6'(3 + i));
            push_exp(1'b1, 6'(3 + i));
            tick_check($sformatf("starve%0d", i));
        end
`ifdef FETCH_DEBUG_PORT_EN
        drive(1'b0, 1'b0, 6'd0, 1'b1, 6'd7);
        chk("slot_gnt", DbgGnt, 1'b1);
        chk("slot_addr", ImemAddress, 6'd7);
        push_exp(1'b0, 6'd0);
        tick_check("dbg_slot");
        chk("slot_dvalid", DbgValid, 1'b1);
        chk("slot_ddata", DbgData, imem_word(6'd7));
        for (int i = 7; i < 10; i++) begin
            drive(1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
            push_exp(1'b1, 6'(i));
            tick_check($sformatf("post%0d", i));
            chk("post_dvalid", DbgValid, 1'b0);
        end
`else
        for (int i = 7; i < 10; i++) begin
            drive(1'b0, 1'b0, 6'd0, 1'b1, 6'd7);
            chk("nodbg_gnt", DbgGnt, 1'b0);
            push_exp(1'b1, 6'(i));
            tick_check($sformatf("post%0d", i));
            chk("nodbg_dvalid", DbgValid, 1'b0);
        end
`endif

        // Reset mid-operation overrides branch and debug request
        Reset = 1'b1;
        drive(1'b0, 1'b1, 6'd33, 1'b1, 6'd7);
        chk("mid_rst_gnt", DbgGnt, 1'b0);
        @(posedge Clk);
        #1;
        chk("mid_rst_valid", InstrValid, 1'b0);
        chk("mid_rst_instr", Instruction, 32'h0);
        chk("mid_rst_pc", InstrPC, 6'd0);
        chk("mid_rst_addr", ImemAddress, 6'd0);
        chk("mid_rst_dvalid", DbgValid, 1'b0);
        chk("mid_rst_halted", Halted, 1'b0);
        $display("step mid_reset: valid=%0b pc=%0d addr=%0d dvalid=%0b",
                 InstrValid, InstrPC, ImemAddress, DbgValid);
        Reset = 1'b0;
        drive(1'b0, 1'b0, 6'd0, 1'b0, 6'd0);
        chk("sb_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
